// File: rtl/spi_master_mc.sv
// Multi-mode SPI master: all four SPI modes, runtime word length, bit order, SCK divider
// and optional chip-select hold between words; one engine shared by several slaves.
module spi_master_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int CS_COUNT   = 4,
    parameter int DIV_WIDTH  = 8,
    parameter int LEN_WIDTH  = $clog2(DATA_WIDTH),
    parameter int SEL_WIDTH  = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // start: single-cycle request, sampled only while idle (busy=0); ignored otherwise.
    // done: single-cycle completion pulse in the first idle cycle, data_out valid from then on.
    input  logic                  start,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic                  hold_cs,
    input  logic [LEN_WIDTH-1:0]  word_len,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic [SEL_WIDTH-1:0]  cs_sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  miso,
    output logic                  mosi,
    output logic                  sck,
    output logic [CS_COUNT-1:0]   cs_n,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out
);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;
    state_t state, state_next;

    logic [DIV_WIDTH-1:0]  cnt, div_q;
    logic [LEN_WIDTH:0]    bit_cnt, n_bits;
    logic [LEN_WIDTH-1:0]  len_q, tx_pos, rx_pos, rx_lo, first_pos;
    logic [DATA_WIDTH-1:0] tx_q, rx_q;
    logic                  cpol_q, cpha_q, lsb_q, hold_q;
    logic                  tick, leading, toggle, finish;

    function automatic logic [CS_COUNT-1:0] cs_decode(input logic [SEL_WIDTH-1:0] sel);
        cs_decode = '1;
        for (int i = 0; i < CS_COUNT; i++)
            if (int'(sel) == i) cs_decode[i] = 1'b0;
    endfunction

    assign busy    = (state != IDLE);
    assign n_bits  = {1'b0, len_q} + 1'b1;
    // bit_cnt counts leading edges taken; with cpha=1 the sample belongs to the previous bit
    assign tx_pos    = lsb_q ? bit_cnt[LEN_WIDTH-1:0] : len_q - bit_cnt[LEN_WIDTH-1:0];
    assign rx_lo     = cpha_q ? bit_cnt[LEN_WIDTH-1:0] - 1'b1 : bit_cnt[LEN_WIDTH-1:0];
    assign rx_pos    = lsb_q ? rx_lo : len_q - rx_lo;
    assign first_pos = lsb_first ? '0 : word_len;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        tick       = (cnt == '0);
        leading    = (sck == cpol_q);
        toggle     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE:  if (start) state_next = LEAD;
            LEAD:  if (tick) begin
                       state_next = XFER;
                       toggle     = 1'b1;
                   end
            // the transfer ends once all bits are clocked and sck is back at its idle level
            XFER:  if (tick) begin
                       if (leading && bit_cnt == n_bits) state_next = TRAIL;
                       else                              toggle     = 1'b1;
                   end
            TRAIL: if (tick) begin
                       state_next = IDLE;
                       finish     = 1'b1;
                   end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            div_q    <= '0;
            bit_cnt  <= '0;
            len_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            hold_q   <= 1'b0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= '1;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            done <= finish;
            if (state == IDLE) begin
                if (start) begin
                    cpol_q  <= cpol;
                    cpha_q  <= cpha;
                    lsb_q   <= lsb_first;
                    hold_q  <= hold_cs;
                    len_q   <= word_len;
                    div_q   <= clk_div;
                    tx_q    <= data_in;
                    cnt     <= clk_div;
                    bit_cnt <= '0;
                    rx_q    <= '0;
                    sck     <= cpol;
                    mosi    <= data_in[first_pos];
                    cs_n    <= cs_decode(cs_sel);
                end
            end else begin
                cnt <= tick ? div_q : cnt - 1'b1;
                if (toggle) begin
                    sck <= ~sck;
                    if (leading) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (cpha_q) mosi <= tx_q[tx_pos];
                        else        rx_q[rx_pos] <= miso;
                    end else if (cpha_q) begin
                        rx_q[rx_pos] <= miso;
                    end else if (bit_cnt != n_bits) begin
                        mosi <= tx_q[tx_pos];
                    end
                end
                if (finish) begin
                    data_out <= rx_q;
                    mosi     <= 1'b0;
                    if (!hold_q) cs_n <= '1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc: directed plus random transfers against an SPI slave model
// and a word-level reference (bit order, timing formulas, chip-select rules).
module tb_spi_master_mc;

    localparam int DW  = 16;
    localparam int CSN = 4;
    localparam int DVW = 8;
    localparam int LW  = 4;
    localparam int SW  = 2;

    logic           clk = 1'b0;
    logic           rst_n, start, cpol, cpha, lsb_first, hold_cs;
    logic [LW-1:0]  word_len;
    logic [DVW-1:0] clk_div;
    logic [SW-1:0]  cs_sel;
    logic [DW-1:0]  data_in, data_out;
    logic           miso, mosi, sck, busy, done;
    logic [CSN-1:0] cs_n;

    int n_chk  = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_q[$];

    // slave model state
    logic          loop_en = 1'b0;
    logic          slv_miso = 1'b0;
    logic          slv_cpol = 1'b0, slv_cpha = 1'b0, slv_lsb = 1'b0;
    logic          slv_prev_busy = 1'b0, slv_prev_sck = 1'b0;
    logic [DW-1:0] slv_resp = '0, slv_rec = '0;
    int            slv_n = 1, slv_ti = 0, slv_ri = 0;

    assign miso = loop_en ? mosi : slv_miso;

    always #5 clk = ~clk;

    spi_master_mc #(.DATA_WIDTH(DW), .CS_COUNT(CSN), .DIV_WIDTH(DVW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .hold_cs(hold_cs), .word_len(word_len), .clk_div(clk_div),
        .cs_sel(cs_sel), .data_in(data_in), .miso(miso), .mosi(mosi), .sck(sck),
        .cs_n(cs_n), .busy(busy), .done(done), .data_out(data_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic slave_bit(input int j);
        return slv_lsb ? slv_resp[j] : slv_resp[slv_n-1-j];
    endfunction

    function automatic logic [DW-1:0] low_bits(input logic [DW-1:0] w, input int n);
        logic [DW-1:0] r = '0;
        for (int j = 0; j < n; j++) r[j] = w[j];
        return r;
    endfunction

    // wire order of a word: element j of the serial sequence at bit j
    function automatic logic [DW-1:0] wire_seq(input logic [DW-1:0] w, input int n, input logic lsb);
        logic [DW-1:0] r = '0;
        for (int j = 0; j < n; j++) r[j] = lsb ? w[j] : w[n-1-j];
        return r;
    endfunction

    function automatic logic [CSN-1:0] cs_exp(input int sel);
        return (sel < CSN) ? ~(CSN'(1) << sel) : '1;
    endfunction

    // SPI slave: reacts to sck edges seen during a transfer
    always @(negedge clk) begin
        if (busy && slv_prev_busy && sck !== slv_prev_sck) begin
            if (sck !== slv_cpol) begin
                if (!slv_cpha) begin
                    if (slv_ri < DW) slv_rec[slv_ri] = mosi;
                    slv_ri++;
                end else begin
                    if (slv_ti < slv_n) slv_miso = slave_bit(slv_ti);
                    slv_ti++;
                end
            end else begin
                if (!slv_cpha) begin
                    slv_ti++;
                    if (slv_ti < slv_n) slv_miso = slave_bit(slv_ti);
                end else begin
                    if (slv_ri < DW) slv_rec[slv_ri] = mosi;
                    slv_ri++;
                end
            end
        end
        slv_prev_busy = busy;
        slv_prev_sck  = sck;
    end

    // Called at a negedge; start is sampled at the following posedge (edge 0).
    task automatic do_xfer(input logic m_cpol, input logic m_cpha, input logic m_lsb,
                           input logic m_hold, input int n, input int h, input int sel,
                           input logic [DW-1:0] din, input logic [DW-1:0] resp, input logic loop);
        int cyc, busy_cnt, edges, first_e, last_e, cs_bad, done_cnt;
        logic prev_sck, got_end;
        logic [CSN-1:0] ecs;
        logic [DW-1:0] exp_rx;
        ecs      = cs_exp(sel);
        loop_en  = loop;
        slv_cpol = m_cpol; slv_cpha = m_cpha; slv_lsb = m_lsb;
        slv_resp = resp; slv_n = n; slv_ti = 0; slv_ri = 0; slv_rec = '0;
        slv_miso = m_cpha ? 1'b0 : slave_bit(0);
        exp_q.push_back(loop ? low_bits(din, n) : low_bits(resp, n));
        cpol = m_cpol; cpha = m_cpha; lsb_first = m_lsb; hold_cs = m_hold;
        word_len = LW'(n - 1); clk_div = DVW'(h - 1); cs_sel = SW'(sel); data_in = din;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; busy_cnt = 0; edges = 0; first_e = 0; last_e = 0; cs_bad = 0; done_cnt = 0;
        prev_sck = sck; got_end = 1'b0;
        while (cyc <= 3000 && !got_end) begin
            if (cyc == 1) begin
                check_eq("busy_rise", busy, 1'b1);
                check_eq("cs_assert", cs_n, ecs);
                check_eq("sck_lead", sck, m_cpol);
            end
            // a stray start while busy must change nothing
            if (cyc == 3) begin start = 1'b1; cs_sel = SW'(sel + 1); data_in = ~din; end
            if (cyc == 4) begin start = 1'b0; cs_sel = SW'(sel); data_in = din; end
            if (busy) begin
                busy_cnt++;
                if (cs_n !== ecs) cs_bad++;
                if (cyc > 1 && sck !== prev_sck) begin
                    edges++;
                    if (first_e == 0) first_e = cyc;
                    last_e = cyc;
                end
            end
            if (done) done_cnt++;
            if (!busy) begin
                got_end = 1'b1;
            end else begin
                prev_sck = sck;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (!got_end) begin
            check_eq("xfer_timeout", 32'd0, 32'd1);
        end else begin
            exp_rx = exp_q.pop_front();
            check_eq("busy_len", busy_cnt, 2*h*(n+1));
            check_eq("done_cycle", cyc, 1 + 2*h*(n+1));
            check_eq("done_pulses", done_cnt, 1);
            check_eq("done_now", done, 1'b1);
            check_eq("first_edge", first_e, 1 + h);
            check_eq("last_edge", last_e, 1 + h + (2*n - 1)*h);
            check_eq("edge_count", edges, 2*n);
            check_eq("cs_during", cs_bad, 0);
            check_eq("data_out", data_out, exp_rx);
            check_eq("mosi_seq", slv_rec, wire_seq(din, n, m_lsb));
            check_eq("slave_bits", slv_ri, n);
            check_eq("cs_after", cs_n, m_hold ? ecs : {CSN{1'b1}});
            check_eq("sck_idle", sck, m_cpol);
            check_eq("mosi_idle", mosi, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_sck"}, sck, 1'b0);
        check_eq({tag, "_mosi"}, mosi, 1'b0);
        check_eq({tag, "_cs_n"}, cs_n, {CSN{1'b1}});
        check_eq({tag, "_data_out"}, data_out, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int lead_cnt, guard, dn;
        logic last_sck;
        rst_n = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; hold_cs = 1'b0;
        word_len = '0; clk_div = '0; cs_sel = '0; data_in = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // mode 0, MSB-first, looped
        do_xfer(1'b0, 1'b0, 1'b0, 1'b0, 16, 2, 0, 16'h5555, 16'h0000, 1'b1);
        // all four modes against the slave model
        for (int m = 0; m < 4; m++)
            do_xfer(m[1], m[0], 1'b0, 1'b0, 16, 2, 1, 16'hA5C3, 16'h3C5A, 1'b0);
        // LSB-first byte, looped
        do_xfer(1'b0, 1'b0, 1'b1, 1'b0, 8, 2, 0, 16'h00B1, 16'h0000, 1'b1);
        // held select on 2, second word on 2 releases it
        do_xfer(1'b0, 1'b0, 1'b0, 1'b1, 16, 1, 2, 16'h1234, 16'hBEEF, 1'b0);
        do_xfer(1'b1, 1'b0, 1'b1, 1'b0, 12, 3, 2, 16'h0ABC, 16'h0F0F, 1'b0);
        // held select on 2, then a word on 3 swaps lines in one cycle
        do_xfer(1'b1, 1'b1, 1'b0, 1'b1, 8, 3, 2, 16'h00C3, 16'h005A, 1'b0);
        do_xfer(1'b0, 1'b1, 1'b1, 1'b0, 4, 1, 3, 16'h0009, 16'h0006, 1'b0);

        repeat (14) begin
            do_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(1, 16), $urandom_range(1, 4),
                    $urandom_range(0, 3), DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // reset during bit 5 of a held mode-3 transfer
        loop_en = 1'b1;
        cpol = 1'b1; cpha = 1'b1; lsb_first = 1'b0; hold_cs = 1'b1;
        word_len = 4'd15; clk_div = 8'd1; cs_sel = 2'd1; data_in = 16'hF00D;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lead_cnt = 0; guard = 0; last_sck = sck;
        while (lead_cnt < 5 && guard < 500) begin
            @(negedge clk);
            guard++;
            if (sck !== last_sck && sck === 1'b0) lead_cnt++;
            last_sck = sck;
        end
        check_eq("reach_bit5", lead_cnt, 5);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        rst_n = 1'b1;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        check_eq("abort_no_done", dn, 0);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_cs_n", cs_n, {CSN{1'b1}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
